// File: rtl/fwd_kin_pkg.sv
// Shared types, constants and number-format helpers for the two-link forward-kinematics engine.
// Angles and lengths are Q16.15; internal arithmetic is 34-bit two's complement.
package fwd_kin_pkg;

    localparam int TW = 34;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUM  = 3'd1,
        S_COR1 = 3'd2,
        S_COR2 = 3'd3,
        S_MUL  = 3'd4,
        S_ADD  = 3'd5,
        S_HOLD = 3'd6
    } state_t;

    localparam logic signed [TW-1:0] L1      = 34'sd360448;  // 11.0
    localparam logic signed [TW-1:0] L2      = 34'sd393216;  // 12.0
    localparam logic signed [TW-1:0] K_GAIN  = 34'sd19898;   // 0.607253
    localparam logic signed [TW-1:0] PI      = 34'sd102944;
    localparam logic signed [TW-1:0] HALF_PI = 34'sd51472;
    localparam logic signed [TW-1:0] TWO_PI  = 34'sd205888;

    // atan(2^-i) in Q.15, rounded to nearest
    function automatic logic signed [TW-1:0] atan_q15(input logic [3:0] i);
        logic signed [TW-1:0] r;
        case (i)
            4'd0:    r = 34'sd25736;
            4'd1:    r = 34'sd15193;
            4'd2:    r = 34'sd8027;
            4'd3:    r = 34'sd4075;
            4'd4:    r = 34'sd2045;
            4'd5:    r = 34'sd1024;
            4'd6:    r = 34'sd512;
            4'd7:    r = 34'sd256;
            4'd8:    r = 34'sd128;
            4'd9:    r = 34'sd64;
            4'd10:   r = 34'sd32;
            4'd11:   r = 34'sd16;
            4'd12:   r = 34'sd8;
            4'd13:   r = 34'sd4;
            4'd14:   r = 34'sd2;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Negative zero collapses to 0 naturally because -0 == 0.
    function automatic logic signed [TW-1:0] sm_to_tc(input logic [31:0] v);
        logic signed [TW-1:0] mag;
        mag = {3'b000, v[30:0]};
        return v[31] ? -mag : mag;
    endfunction

    // Saturates magnitudes beyond 31 bits; zero always comes out as +0.
    function automatic logic [31:0] tc_to_sm(input logic signed [TW-1:0] v);
        logic [TW-1:0] mag;
        mag = v[TW-1] ? 34'(-v) : 34'(v);
        if (mag[TW-1:31] != 3'b000)
            mag = 34'h0_7FFF_FFFF;
        return {v[TW-1] && (mag[30:0] != 31'd0), mag[30:0]};
    endfunction

endpackage

// File: rtl/fwd_kin_cordic.sv
// Iterative rotation-mode CORDIC producing sin/cos of a Q.15 angle in [-pi, pi].
// One setup cycle on start (quadrant fold to +-pi/2) followed by ITERS micro-rotations.
module fk_cordic
    import fwd_kin_pkg::*;
#(
    parameter int ITERS = 15
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [TW-1:0] angle,
    output logic signed [TW-1:0] sin_val,
    output logic signed [TW-1:0] cos_val,
    output logic                 done
);

    localparam logic [3:0] LAST = 4'(ITERS - 1);

    logic signed [TW-1:0] x_q, y_q, z_q;
    logic [3:0]           iter;
    logic                 busy;
    logic                 neg;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            x_q  <= '0;
            y_q  <= '0;
            z_q  <= '0;
            iter <= '0;
            busy <= 1'b0;
            neg  <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            iter <= '0;
            x_q  <= K_GAIN;
            y_q  <= '0;
            // Outside +-pi/2 rotate by a-+pi instead and flip the result vector.
            if (angle > HALF_PI) begin
                z_q <= angle - PI;
                neg <= 1'b1;
            end else if (angle < -HALF_PI) begin
                z_q <= angle + PI;
                neg <= 1'b1;
            end else begin
                z_q <= angle;
                neg <= 1'b0;
            end
        end else if (busy) begin
            if (!z_q[TW-1]) begin
                x_q <= x_q - (y_q >>> iter);
                y_q <= y_q + (x_q >>> iter);
                z_q <= z_q - atan_q15(iter);
            end else begin
                x_q <= x_q + (y_q >>> iter);
                y_q <= y_q - (x_q >>> iter);
                z_q <= z_q + atan_q15(iter);
            end
            iter <= iter + 4'd1;
            if (iter == LAST)
                busy <= 1'b0;
        end
    end

    assign done    = busy && (iter == LAST);
    assign cos_val = neg ? -x_q : x_q;
    assign sin_val = neg ? -y_q : y_q;

endmodule

// File: rtl/fwd_kin.sv
// Two-link planar forward kinematics: x = 11cos(t1)+12cos(t1+t2), y = 11sin(t1)+12sin(t1+t2).
// One shared CORDIC and one shared multiplier; optional range check under FWD_KIN_ANGLE_CHK_EN.
module fwd_kin
    import fwd_kin_pkg::*;
#(
    parameter int BIT_WIDTH    = 32,
    parameter int FRACTIONS    = 15,
    parameter int CORDIC_ITERS = 15
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] theta1,
    input  logic [BIT_WIDTH-1:0] theta2,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_WIDTH-1:0] x,
    output logic [BIT_WIDTH-1:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    // Handshake: a pair moves in on a rising edge with in_valid & in_ready, a result moves
    // out with out_valid & out_ready; both sides hold their payload stable until that edge.

    localparam logic signed [67:0] RND = 68'sd1 <<< (FRACTIONS - 1);

    state_t               state;
    logic signed [TW-1:0] th1_q, th2_q, t12_q;
    logic signed [TW-1:0] c1_q, s1_q;
    logic signed [TW-1:0] p_c1, p_c12, p_s1, p_s12;
    logic [1:0]           mcnt;
    logic                 cor_start;

    logic signed [TW-1:0] cor_angle, cor_sin, cor_cos;
    logic                 cor_done;

    logic signed [TW-1:0] t12_raw, t12_wrap;
    logic signed [TW-1:0] mul_a, mul_b, mul_r;
    logic signed [67:0]   mul_p, mul_rnd;
    logic [33:0]          mul_unused;
    logic signed [TW-1:0] x_sum, y_sum;

`ifdef FWD_KIN_ANGLE_CHK_EN
    logic err_pend;
`endif

    assign cor_angle = (state == S_COR1) ? th1_q : t12_q;

    fk_cordic #(.ITERS(CORDIC_ITERS)) u_cordic (
        .clock   (clock),
        .rst     (rst),
        .start   (cor_start),
        .angle   (cor_angle),
        .sin_val (cor_sin),
        .cos_val (cor_cos),
        .done    (cor_done)
    );

    always_comb begin
        t12_raw = th1_q + th2_q;
        if (t12_raw > PI)
            t12_wrap = t12_raw - TWO_PI;
        else if (t12_raw < -PI)
            t12_wrap = t12_raw + TWO_PI;
        else
            t12_wrap = t12_raw;
    end

    // The t12 results are still on the CORDIC outputs throughout MUL.
    always_comb begin
        mul_a = L1;
        mul_b = c1_q;
        case (mcnt)
            2'd0: begin mul_a = L1; mul_b = c1_q;    end
            2'd1: begin mul_a = L2; mul_b = cor_cos; end
            2'd2: begin mul_a = L1; mul_b = s1_q;    end
            2'd3: begin mul_a = L2; mul_b = cor_sin; end
            default: ;
        endcase
        mul_p      = 68'(mul_a) * 68'(mul_b);
        mul_rnd    = mul_p + RND;
        mul_r      = mul_rnd[FRACTIONS+TW-1:FRACTIONS];
        mul_unused = {mul_rnd[67:FRACTIONS+TW], mul_rnd[FRACTIONS-1:0]};
    end

    assign x_sum     = p_c1 + p_c12;
    assign y_sum     = p_s1 + p_s12;
    assign dbg_state = state;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            th1_q     <= '0;
            th2_q     <= '0;
            t12_q     <= '0;
            c1_q      <= '0;
            s1_q      <= '0;
            p_c1      <= '0;
            p_c12     <= '0;
            p_s1      <= '0;
            p_s12     <= '0;
            mcnt      <= '0;
            cor_start <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x         <= '0;
            y         <= '0;
`ifdef FWD_KIN_ANGLE_CHK_EN
            err       <= 1'b0;
            err_pend  <= 1'b0;
`endif
        end else begin
            cor_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        th1_q    <= sm_to_tc(theta1);
                        th2_q    <= sm_to_tc(theta2);
                        in_ready <= 1'b0;
                        state    <= S_SUM;
`ifdef FWD_KIN_ANGLE_CHK_EN
                        err      <= 1'b0;
                        err_pend <= (theta1[30:0] > 31'(PI)) || (theta2[30:0] > 31'(PI));
`endif
                    end
                end
                S_SUM: begin
                    t12_q     <= t12_wrap;
                    cor_start <= 1'b1;
                    state     <= S_COR1;
                end
                S_COR1: begin
                    if (cor_done) begin
                        cor_start <= 1'b1;
                        state     <= S_COR2;
                    end
                end
                S_COR2: begin
                    // First COR2 cycle: CORDIC still presents the theta1 results.
                    if (cor_start) begin
                        c1_q <= cor_cos;
                        s1_q <= cor_sin;
                    end
                    if (cor_done) begin
                        mcnt  <= 2'd0;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    case (mcnt)
                        2'd0:    p_c1  <= mul_r;
                        2'd1:    p_c12 <= mul_r;
                        2'd2:    p_s1  <= mul_r;
                        default: p_s12 <= mul_r;
                    endcase
                    mcnt <= mcnt + 2'd1;
                    if (mcnt == 2'd3)
                        state <= S_ADD;
                end
                S_ADD: begin
`ifdef FWD_KIN_ANGLE_CHK_EN
                    err <= err_pend;
                    x   <= err_pend ? '0 : tc_to_sm(x_sum);
                    y   <= err_pend ? '0 : tc_to_sm(y_sum);
`else
                    x   <= tc_to_sm(x_sum);
                    y   <= tc_to_sm(y_sum);
`endif
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef FWD_KIN_ANGLE_CHK_EN
    assign err = 1'b0;
`endif

endmodule
